// File: rtl/res_wb_scheduler.sv
// Result write-back scheduler: buffers MAC/maxpool result bytes and writes them round-robin into four res_ram banks.
// Optional sticky protocol-error output is built when the RES_WB_ERR_EN macro is defined.
module res_wb_scheduler #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] base_addr,
    input  logic [13:0] total,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [3:0]  wren,
    output logic [13:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        done
`ifdef RES_WB_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [13:0]     accepted_q, accepted_d;
    logic [13:0]     total_q, total_d;
    logic [13:0]     remaining_q, remaining_d;
    logic [13:0]     addr_q, addr_d;
    logic [1:0]      bank_q, bank_d;
    logic [3:0]      wren_q, wren_d;
    logic [13:0]     wr_addr_q, wr_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            push_s;
    logic            pop_s;
    logic            start_acc_s;

    assign start_acc_s = (state_q == S_IDLE) && start;
    assign push_s      = in_valid && in_ready_q;
    assign pop_s       = (state_q == S_RUN) && (count_q != {CW{1'b0}});

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: RUN ends one cycle after the final byte has been written
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (total == 14'd0) ? S_DONE : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (remaining_q == 14'd0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs, registered from next-cycle state so in_ready tracks registered occupancy
    always_comb begin
        busy_d     = (state_d == S_RUN);
        done_d     = (state_d == S_DONE);
        in_ready_d = (state_d == S_RUN) && (count_d < DEPTH_C) && (accepted_d < total_d);
    end

    // Datapath next-state: pass setup, FIFO push/pop, bank rotation and write port
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        accepted_d  = accepted_q;
        total_d     = total_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        bank_d      = bank_q;
        wren_d      = 4'b0000;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        if (start_acc_s) begin
            addr_d      = base_addr;
            total_d     = total;
            remaining_d = total;
            accepted_d  = 14'd0;
            bank_d      = 2'd0;
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
                accepted_d      = accepted_q + 14'd1;
            end else begin
                wr_ptr_d   = wr_ptr_q;
                accepted_d = accepted_q;
            end

            if (pop_s) begin
                wren_d      = 4'b0001 << bank_q;
                wr_addr_d   = addr_q;
                wr_data_d   = mem_q[rd_ptr_q];
                rd_ptr_d    = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
                bank_d      = bank_q + 2'd1;
                remaining_d = remaining_q - 14'd1;
                // The address advances once per four-bank row; 14-bit wrap is intended
                if (bank_q == 2'd3) begin
                    addr_d = addr_q + 14'd1;
                end else begin
                    addr_d = addr_q;
                end
            end else begin
                wren_d = 4'b0000;
            end
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            accepted_q  <= 14'd0;
            total_q     <= 14'd0;
            remaining_q <= 14'd0;
            addr_q      <= 14'd0;
            bank_q      <= 2'd0;
            wren_q      <= 4'b0000;
            wr_addr_q   <= 14'd0;
            wr_data_q   <= 8'd0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            accepted_q  <= accepted_d;
            total_q     <= total_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            bank_q      <= bank_d;
            wren_q      <= wren_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef RES_WB_ERR_EN
    logic err_q, err_d;

    // Sticky error on data offered while idle or beyond the pass length
    always_comb begin
        if (start_acc_s) begin
            err_d = 1'b0;
        end else if (in_valid && ((state_q == S_IDLE) || (accepted_q >= total_q))) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Error flag register
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign in_ready = in_ready_q;
    assign wren     = wren_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_res_wb_scheduler.sv
// Directed, table-driven bench for res_wb_scheduler (default FIFO_DEPTH=4).
module tb_res_wb_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] base_addr;
    logic [13:0] total;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [3:0]  wren;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
`ifdef RES_WB_ERR_EN
    logic        err;
`endif

    int checks   = 0;
    int failures = 0;

    res_wb_scheduler #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .total     (total),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wren      (wren),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
`ifdef RES_WB_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] base;
        logic [13:0] tot;
        logic [7:0]  d0;
        bit          restart;
        logic [13:0] hold_addr;
        logic [7:0]  hold_data;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Runs one pass from a negedge: bytes d0, d0+1, ... ; checks every write against bank/addr model
    task automatic run_pass(input logic [13:0] b, input logic [13:0] t, input logic [7:0] d0,
                            input bit restart);
        int  sent = 0;
        int  w = 0;
        int  last_wr = 0;
        int  stalls = 0;
        bit  seen_done = 1'b0;
        start     = 1'b1;
        base_addr = b;
        total     = t;
        in_valid  = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        base_addr = 14'h0;
        total     = 14'h0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (wren != 4'b0000) begin
                chk("wren_onehot", 32'(wren), 32'(4'b0001 << (w % 4)));
                chk("wr_addr", 32'(wr_addr), 32'((int'(b) + w / 4) & 16'h3FFF));
                chk("wr_data", 32'(wr_data), 32'((int'(d0) + w) & 8'hFF));
                w++;
                last_wr = cyc;
            end
            if (done) begin
                chk("done_write_count", 32'(w), 32'(t));
                if (t != 14'd0) chk("done_gap", 32'(cyc - last_wr), 32'd1);
                chk("busy_at_done", 32'(busy), 32'd0);
                seen_done = 1'b1;
                break;
            end
            chk("busy_in_run", 32'(busy), 32'(t != 14'd0));
            if (restart && cyc == 2) begin
                start     = 1'b1;
                base_addr = 14'h3FFF;
                total     = 14'd2;
            end else begin
                start     = 1'b0;
                base_addr = 14'h0;
                total     = 14'h0;
            end
            in_valid = (sent < int'(t));
            in_data  = 8'((int'(d0) + sent) & 8'hFF);
            if (in_valid && !in_ready) stalls++;
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        if (!seen_done) chk("done_timeout", 32'd0, 32'd1);
        chk("no_stall", 32'(stalls), 32'd0);
        in_valid = 1'b0;
        start    = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_wren", 32'(wren), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        int w;
        int sent;

        vecs[0] = '{14'd0,     14'd8, 8'h01, 1'b0, 14'd1,     8'h08};
        vecs[1] = '{14'h3FFF,  14'd5, 8'h10, 1'b0, 14'd0,     8'h14};
        vecs[2] = '{14'd100,   14'd6, 8'hA0, 1'b0, 14'd101,   8'hA5};
        vecs[3] = '{14'd0,     14'd0, 8'h00, 1'b0, 14'd101,   8'hA5};
        vecs[4] = '{14'h1234,  14'd1, 8'h55, 1'b0, 14'h1234,  8'h55};
        vecs[5] = '{14'd7,     14'd9, 8'hC0, 1'b1, 14'd9,     8'hC8};

        reset     = 1'b1;
        start     = 1'b0;
        base_addr = 14'h0;
        total     = 14'h0;
        in_valid  = 1'b0;
        in_data   = 8'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_wren", 32'(wren), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef RES_WB_ERR_EN
        chk("rst_err", 32'(err), 32'd0);
`endif

        for (int i = 0; i < 6; i++) begin
            run_pass(vecs[i].base, vecs[i].tot, vecs[i].d0, vecs[i].restart);
            chk("hold_wr_addr", 32'(wr_addr), 32'(vecs[i].hold_addr));
            chk("hold_wr_data", 32'(wr_data), 32'(vecs[i].hold_data));
        end

        // Reset in the middle of an 8-byte pass, after the third write
        start     = 1'b1;
        base_addr = 14'd0;
        total     = 14'd8;
        @(negedge clk);
        start = 1'b0;
        w     = 0;
        sent  = 0;
        for (int c = 0; c < 50; c++) begin
            if (wren != 4'b0000) w++;
            if (w == 3) break;
            in_valid = (sent < 8);
            in_data  = 8'(sent + 1);
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        chk("mid_reset_writes_seen", 32'(w), 32'd3);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_wren", 32'(wren), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_wren", 32'(wren), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        run_pass(14'h200, 14'd4, 8'h30, 1'b0);
        chk("post_rst_hold_addr", 32'(wr_addr), 32'h200);
        chk("post_rst_hold_data", 32'(wr_data), 32'h33);

`ifdef RES_WB_ERR_EN
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("err_set_idle", 32'(err), 32'd1);
        @(negedge clk);
        chk("err_sticky", 32'(err), 32'd1);
        run_pass(14'd0, 14'd1, 8'h77, 1'b0);
        chk("err_cleared_by_start", 32'(err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/res_wb_scheduler.md
RES_WB_SCHEDULER -- requirements
Module: res_wb_scheduler

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-003 SHALL have port: start  input  1  one-cycle request to begin a write-back pass.
REQ-004 SHALL have port: base_addr  input  14  first res_ram word address of the pass, sampled on accepted start.
REQ-005 SHALL have port: total  input  14  number of result bytes in the pass, sampled on accepted start.
REQ-006 SHALL have port: in_valid  input  1  MAC/maxpool result byte available.
REQ-007 SHALL have port: in_data  input  8  result byte.
REQ-008 SHALL have port: in_ready  output  1  scheduler accepts in_data this cycle.
REQ-009 SHALL have port: wren  output  4  one-hot write enable, bit i drives res_ram bank i.
REQ-010 SHALL have port: wr_addr  output  14  shared wraddress to all four banks.
REQ-011 SHALL have port: wr_data  output  8  shared write data to all four banks.
REQ-012 SHALL have port: busy  output  1  pass in progress.
REQ-013 SHALL have port: done  output  1  one-cycle pulse at pass completion.
REQ-014 SHALL have parameter: FIFO_DEPTH, default 4, input buffer entries (power of two, 2..16).

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; busy=1 only in RUN.
REQ-016 IDLE: start=1 SHALL latch base_addr into addr, total into remaining, clear bank to 0, and go to RUN; if total=0, SHALL go to DONE instead.
REQ-017 start SHALL be ignored in RUN and DONE.
REQ-018 in_ready SHALL be 1 only in RUN when FIFO occupancy < FIFO_DEPTH and accepted-count < total (registered occupancy, no lookahead).
REQ-019 A beat SHALL be accepted on an edge where in_valid=1 and in_ready=1; in_valid without in_ready SHALL be held by the producer, not dropped.
REQ-020 In RUN, whenever the FIFO is non-empty, one entry SHALL pop per cycle; the pop edge SHALL register wren=1<<bank, wr_addr=addr, wr_data=entry.
REQ-021 wren SHALL be a one-cycle pulse per popped byte and 4'b0000 in every other cycle.
REQ-022 Minimum latency SHALL be 2 edges: byte accepted at edge k into an empty FIFO appears on wren/wr_data after edge k+1.
REQ-023 Bank SHALL advance 0->1->2->3->0 per write; addr SHALL increment by 1 only on the write to bank 3, wrapping 16383->0.
REQ-024 Simultaneous push and pop in one cycle SHALL keep occupancy unchanged and preserve byte order.
REQ-025 After the write of byte number total, the FSM SHALL go to DONE; DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-026 wr_addr and wr_data SHALL hold their last value when wren=0.

Reset
REQ-027 reset SHALL force IDLE, FIFO empty, bank=0, addr=0, remaining=0, wren=0, wr_addr=0, wr_data=0, in_ready=0, busy=0, done=0 on the next edge, including mid-pass; no write pulse SHALL follow a reset edge.

Configuration
REQ-028 Macro RES_WB_ERR_EN defined: SHALL add output err (1 bit, reset 0), set sticky when in_valid=1 in IDLE or after total bytes accepted, cleared only by reset or accepted start.
REQ-029 Macro RES_WB_ERR_EN undefined: err port and its logic SHALL not exist; behaviour otherwise identical.

Verification
REQ-030 start, base_addr=0, total=8, in_valid held 1 with bytes 1..8 -> wren 1,2,4,8,1,2,4,8; wr_addr 0,0,0,0,1,1,1,1; done pulse one cycle after 8th write.
REQ-031 base_addr=16383, total=5 -> byte 5 written to bank 0 at wr_addr 0 (wrap).
REQ-032 total=6, write path stalled is impossible, so burst 6 bytes with FIFO_DEPTH=4 -> in_ready stays 1 (pop rate matches), order preserved, no byte lost.
REQ-033 total=0 -> busy never 1, done pulses cycle after start, wren stays 0.
REQ-034 reset asserted after 3 of 8 writes -> wren 0 from next edge, busy 0, subsequent start with total=4 writes banks 0..3 at base_addr.
REQ-035 RES_WB_ERR_EN defined, in_valid=1 while IDLE -> err=1 and stays 1 until next accepted start.
